// File: rtl/smachine_pkg.sv
// Shared types for the S-Machine register-bank access path.
package smachine_pkg;

   localparam int SM_DATA_W = 16;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_MOVE  = 2'b10,
      OP_SWAP  = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_A  = 3'd1,
      ST_CAP_A = 3'd2,
      ST_RD_B  = 3'd3,
      ST_CAP_B = 3'd4,
      ST_WR_A  = 3'd5,
      ST_WR_B  = 3'd6,
      ST_RESP  = 3'd7
   } state_t;

endpackage

// File: rtl/reg_access_ctrl.sv
// Register-bank sequencer: turns READ/WRITE/MOVE/SWAP requests into
// bank strobes and returns one response per request.
module reg_access_ctrl
   import smachine_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter int DATA_W   = SM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_dst,
   input  logic [ADDR_W-1:0] req_src,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              reg_en,
   output logic [ADDR_W-1:0] reg_sel,
   output logic              reg_rw,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic [DATA_W-1:0] reg_rdata
);

   localparam logic [ADDR_W:0] NREG = (ADDR_W+1)'(NUM_REGS);

   state_t            state;
   state_t            nxt;
   op_t               op_q;
   op_t               op_in;
   logic [ADDR_W-1:0] dst_q;
   logic [ADDR_W-1:0] src_q;
   logic [DATA_W-1:0] cap_a;

   logic              accept;
   logic              bad;
   logic              en_n;
   logic              rw_n;
   logic [ADDR_W-1:0] sel_n;
   logic [DATA_W-1:0] wdata_n;

   assign op_in  = op_t'(req_op);
   assign accept = (state == ST_IDLE) && req_valid && req_ready;

   always_comb begin
      bad = ({1'b0, req_dst} >= NREG);
      if ((op_in == OP_MOVE) || (op_in == OP_SWAP))
         bad = bad || ({1'b0, req_src} >= NREG);
   end

   always_comb begin
      nxt = state;
      unique case (state)
         ST_IDLE:
            if (accept) begin
               if (bad)
                  nxt = ST_RESP;
               else if (op_in == OP_WRITE)
                  nxt = ST_WR_A;
               else
                  nxt = ST_RD_A;
            end
         ST_RD_A:  nxt = ST_CAP_A;
         ST_CAP_A:
            if (op_q == OP_READ)
               nxt = ST_RESP;
            else if (op_q == OP_MOVE)
               nxt = ST_WR_A;
            else
               nxt = ST_RD_B;
         ST_RD_B:  nxt = ST_CAP_B;
         ST_CAP_B: nxt = ST_WR_A;
         ST_WR_A:  nxt = (op_q == OP_SWAP) ? ST_WR_B : ST_RESP;
         ST_WR_B:  nxt = ST_RESP;
         ST_RESP:  if (rsp_ready) nxt = ST_IDLE;
         default:  nxt = ST_IDLE;
      endcase
   end

   // Bank outputs are registered, so they are derived from the next state.
   // Write data into WR_A comes straight off reg_rdata when it follows a CAP.
   always_comb begin
      en_n    = 1'b0;
      rw_n    = 1'b0;
      sel_n   = '0;
      wdata_n = '0;
      unique case (nxt)
         ST_RD_A: begin
            en_n  = 1'b1;
            sel_n = (op_in == OP_MOVE) ? req_src : req_dst;
         end
         ST_RD_B: begin
            en_n  = 1'b1;
            sel_n = src_q;
         end
         ST_WR_A: begin
            en_n    = 1'b1;
            rw_n    = 1'b1;
            sel_n   = (state == ST_IDLE) ? req_dst : dst_q;
            wdata_n = (state == ST_IDLE) ? req_data : reg_rdata;
         end
         ST_WR_B: begin
            en_n    = 1'b1;
            rw_n    = 1'b1;
            sel_n   = src_q;
            wdata_n = cap_a;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         op_q      <= OP_READ;
         dst_q     <= '0;
         src_q     <= '0;
         cap_a     <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
         reg_en    <= 1'b0;
         reg_rw    <= 1'b0;
         reg_sel   <= '0;
         reg_wdata <= '0;
      end else begin
         state     <= nxt;
         req_ready <= (nxt == ST_IDLE);
         reg_en    <= en_n;
         reg_rw    <= rw_n;
         reg_sel   <= sel_n;
         reg_wdata <= wdata_n;
         if (accept) begin
            op_q  <= op_in;
            dst_q <= req_dst;
            src_q <= req_src;
            cap_a <= req_data;
         end
         if (state == ST_CAP_A)
            cap_a <= reg_rdata;
         if ((nxt == ST_RESP) && (state != ST_RESP)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= (state == ST_IDLE);
            if (state == ST_IDLE)
               rsp_data <= '0;
            else if (state == ST_CAP_A)
               rsp_data <= reg_rdata;
            else
               rsp_data <= cap_a;
         end else if ((state == ST_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Scoreboard bench for reg_access_ctrl against an 8-entry bank model.
module tb_reg_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [2:0]  req_dst = 3'd0;
   logic [2:0]  req_src = 3'd0;
   logic [15:0] req_data = 16'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        reg_en;
   logic [2:0]  reg_sel;
   logic        reg_rw;
   logic [15:0] reg_wdata;
   logic [15:0] reg_rdata = 16'h0;

   reg_access_ctrl #(.NUM_REGS(6), .ADDR_W(3), .DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_dst(req_dst), .req_src(req_src),
      .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .reg_en(reg_en), .reg_sel(reg_sel), .reg_rw(reg_rw),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rw;
      logic [2:0]  sel;
      logic [15:0] wd;
   } stb_t;

   typedef struct packed {
      logic        err;
      logic [15:0] data;
      logic [7:0]  lat;
   } rsp_t;

   stb_t stb_q[$];
   rsp_t rsp_q[$];

   logic [15:0] mem [8];
   int cyc = 0;
   int acc_cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   logic seen = 1'b0;
   logic [15:0] hold = 16'h0;

   initial foreach (mem[i]) mem[i] = 16'h0;

   // bank: one-cycle read latency
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reg_en) begin
         if (reg_rw)
            mem[reg_sel] <= reg_wdata;
         else
            reg_rdata <= mem[reg_sel];
      end
   end

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
      end else begin
         if (reg_en) begin
            if (stb_q.size() == 0) begin
               check("strobe_unexp", {reg_rw, reg_sel}, 64'hdead);
            end else begin
               stb_t e;
               e = stb_q.pop_front();
               check("strobe_rw", reg_rw, e.rw);
               check("strobe_sel", reg_sel, e.sel);
               if (e.rw) check("strobe_wdata", reg_wdata, e.wd);
            end
         end
         if (rsp_valid) begin
            if (!seen) begin
               seen = 1'b1;
               hold = rsp_data;
               if (rsp_q.size() == 0) begin
                  check("rsp_unexp", rsp_data, 64'hdead);
               end else begin
                  rsp_t r;
                  r = rsp_q.pop_front();
                  check("rsp_data", rsp_data, r.data);
                  check("rsp_err", rsp_err, r.err);
                  check("rsp_lat", cyc - acc_cyc + 1, r.lat);
               end
            end else begin
               check("rsp_hold", rsp_data, hold);
            end
            if (rsp_ready) seen = 1'b0;
         end
      end
   end

   task automatic stb(logic rw, logic [2:0] sel, logic [15:0] wd);
      stb_q.push_back('{rw: rw, sel: sel, wd: wd});
   endtask

   task automatic send(logic [1:0] op, logic [2:0] dst, logic [2:0] src,
                       logic [15:0] data);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) check("req_ready_to", 0, 1);
      req_valid = 1'b1;
      req_op    = op;
      req_dst   = dst;
      req_src   = src;
      req_data  = data;
      @(posedge clk); #1;
      acc_cyc   = cyc;
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_dst   = 3'($urandom);
      req_src   = 3'($urandom);
      req_data  = 16'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!req_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) check("done_to", 0, 1);
   endtask

   task automatic do_req(logic [1:0] op, logic [2:0] dst, logic [2:0] src,
                         logic [15:0] data, logic err, logic [15:0] ed,
                         logic [7:0] lat);
      rsp_q.push_back('{err: err, data: ed, lat: lat});
      send(op, dst, src, data);
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_outs", {req_ready, rsp_valid, rsp_err, rsp_data, reg_en,
                         reg_rw, reg_sel, reg_wdata}, 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("ready_pre", req_ready, 0);
      @(posedge clk); #1;
      check("ready_post_rst", req_ready, 1);

      stb(1, 3, 16'hBEEF);
      do_req(2'b01, 3, 0, 16'hBEEF, 0, 16'hBEEF, 2);
      stb(0, 3, 0);
      do_req(2'b00, 3, 0, 16'h0, 0, 16'hBEEF, 3);
      stb(1, 1, 16'h1234);
      do_req(2'b01, 1, 0, 16'h1234, 0, 16'h1234, 2);
      stb(1, 2, 16'h5678);
      do_req(2'b01, 2, 0, 16'h5678, 0, 16'h5678, 2);

      stb(0, 1, 0); stb(0, 2, 0);
      stb(1, 1, 16'h5678); stb(1, 2, 16'h1234);
      do_req(2'b11, 1, 2, 16'h0, 0, 16'h1234, 7);

      // MOVE r2 -> r5 with a 4-cycle response stall
      stb(0, 2, 0); stb(1, 5, 16'h1234);
      rsp_q.push_back('{err: 0, data: 16'h1234, lat: 4});
      rsp_ready = 1'b0;
      send(2'b10, 5, 2, 16'h0);
      for (int n = 0; n < 20 && !rsp_valid; n++) begin
         @(posedge clk); #1;
      end
      check("stall_valid", rsp_valid, 1);
      for (int i = 0; i < 4; i++) begin
         check("stall_ready", req_ready, 0);
         check("stall_hold", rsp_valid, 1);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      wait_done();
      check("r5_moved", mem[5], 16'h1234);

      do_req(2'b00, 7, 0, 16'h0, 1, 16'h0, 1);
      do_req(2'b00, 6, 0, 16'h0, 1, 16'h0, 1);
      do_req(2'b10, 0, 6, 16'h0, 1, 16'h0, 1);
      do_req(2'b01, 6, 0, 16'hAAAA, 1, 16'h0, 1);
      stb(0, 5, 0);
      do_req(2'b00, 5, 7, 16'h0, 0, 16'h1234, 3);

      stb(0, 3, 0); stb(0, 3, 0);
      stb(1, 3, 16'hBEEF); stb(1, 3, 16'hBEEF);
      do_req(2'b11, 3, 3, 16'h0, 0, 16'hBEEF, 7);
      check("swap_same", mem[3], 16'hBEEF);

      // reset lands in CAP_B of a SWAP r1<->r2; no writes may occur
      stb(0, 1, 0); stb(0, 2, 0);
      send(2'b11, 1, 2, 16'h0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1 check("midrst_outs", {req_ready, rsp_valid, rsp_err, rsp_data,
                               reg_en, reg_rw, reg_sel, reg_wdata}, 64'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_rst", req_ready, 1);
      stb(0, 1, 0);
      do_req(2'b00, 1, 0, 16'h0, 0, 16'h5678, 3);
      check("r2_kept", mem[2], 16'h1234);

      repeat (3) @(posedge clk);
      #1;
      check("stb_q_left", stb_q.size(), 0);
      check("rsp_q_left", rsp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
